// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared types and helpers for the EX->MEM->WB slice (mem_stage_pipe).
//   DEF_*     : default widths/depth used by the stage structs and interface
//   ex_mem_t  : contents of the EX/MEM stage register
//   mem_wb_t  : contents of the MEM/WB stage register
//   addr_in_range() : true when an address falls inside the implemented RAM
// ---------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int          DEF_DATA_W = 24;
  localparam int          DEF_DEST_W = 4;
  localparam int          DEF_ADDR_W = 17;
  localparam int unsigned DEF_DEPTH  = 1024;

  typedef struct packed {
    logic                  valid;
    logic                  wbEn;
    logic                  rdEn;
    logic                  wrEn;
    logic [DEF_DEST_W-1:0] dest;
    logic [DEF_DATA_W-1:0] aluResult;
    logic [DEF_DATA_W-1:0] writeData;
  } ex_mem_t;

  // load/loadOk remember how wb_data must be formed once the RAM has answered
  typedef struct packed {
    logic                  valid;
    logic                  wbEn;
    logic                  load;
    logic                  loadOk;
    logic [DEF_DEST_W-1:0] dest;
    logic [DEF_DATA_W-1:0] aluResult;
  } mem_wb_t;

  function automatic logic addr_in_range(input logic [DEF_ADDR_W-1:0] addr,
                                         input int unsigned depth);
    return 32'(addr) < depth;
  endfunction

endpackage

// File: rtl/mem_stage_pipe_if.sv
// ---------------------------------------------------------------------------
// mem_stage_pipe_if
// Bundles the EX-side inputs, WB-side outputs and the debug port of
// mem_stage_pipe.
//   master : the EX stage / testbench side (drives instruction, stall, flush)
//   slave  : the mem_stage_pipe side (drives WB results, debug data, error)
// ---------------------------------------------------------------------------
interface mem_stage_pipe_if
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEST_W = DEF_DEST_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              valid_in;
  logic              writeback_enable;
  logic              mem_read_enable;
  logic              mem_write_enable;
  logic [DEST_W-1:0] instruction_dest;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] write_data;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] address_b;

  logic              valid_out;
  logic              writeback_enable_out;
  logic [DEST_W-1:0] instruction_dest_out;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] alu_result_out;
  logic [DATA_W-1:0] read_data_b;
  logic              addr_error;

  modport master (
    output valid_in, writeback_enable, mem_read_enable, mem_write_enable,
           instruction_dest, alu_result, write_data, stall, flush, address_b,
    input  valid_out, writeback_enable_out, instruction_dest_out, wb_data,
           alu_result_out, read_data_b, addr_error
  );

  modport slave (
    input  valid_in, writeback_enable, mem_read_enable, mem_write_enable,
           instruction_dest, alu_result, write_data, stall, flush, address_b,
    output valid_out, writeback_enable_out, instruction_dest_out, wb_data,
           alu_result_out, read_data_b, addr_error
  );

endinterface

// File: rtl/dp_data_ram.sv
// ---------------------------------------------------------------------------
// dp_data_ram
// Single-clock dual-port data RAM, DATA_W x DEPTH, read-first.
//   clk      : clock
//   enA_i    : port A enable (write when weA_i, otherwise read)
//   weA_i    : port A write select
//   addrA_i  : port A word index
//   wdataA_i : port A write data
//   rdataA_o : port A registered read data (holds when port A is idle)
//   addrB_i  : port B word index, read every cycle
//   rdataB_o : port B registered read data
// Contents and read registers are not reset so the array maps onto block RAM.
// ---------------------------------------------------------------------------
module dp_data_ram #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              enA_i,
  input  logic              weA_i,
  input  logic [IDX_W-1:0]  addrA_i,
  input  logic [DATA_W-1:0] wdataA_i,
  output logic [DATA_W-1:0] rdataA_o,
  input  logic [IDX_W-1:0]  addrB_i,
  output logic [DATA_W-1:0] rdataB_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdataA_q;
  logic [DATA_W-1:0] rdataB_q;

  // Non-blocking reads sample the array before this edge's write lands,
  // which gives read-first behaviour on a port A/B address collision.
  always_ff @(posedge clk) begin
    if (enA_i) begin
      if (weA_i) begin
        mem_q[addrA_i] <= wdataA_i;
      end else begin
        rdataA_q <= mem_q[addrA_i];
      end
    end
    rdataB_q <= mem_q[addrB_i];
  end

  assign rdataA_o = rdataA_q;
  assign rdataB_o = rdataB_q;

endmodule

// File: rtl/mem_stage_pipe.sv
// ---------------------------------------------------------------------------
// mem_stage_pipe
// EX/MEM register, data RAM and MEM/WB register between the ALU stage and
// register-file writeback.
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_stage_pipe_if.slave
//          in : valid_in, writeback_enable, mem_read_enable, mem_write_enable,
//               instruction_dest, alu_result, write_data, stall, flush,
//               address_b
//          out: valid_out, writeback_enable_out, instruction_dest_out,
//               wb_data, alu_result_out, read_data_b, addr_error
// ---------------------------------------------------------------------------
module mem_stage_pipe
  import mem_stage_pkg::*;
#(
  parameter int          DATA_W = DEF_DATA_W,
  parameter int          ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  mem_stage_pipe_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  ex_mem_t           exMem_q, exMem_d;
  mem_wb_t           memWb_q, memWb_d;
  logic              addrError_q, addrError_d;
  logic              portBOk_q, portBOk_d;

  logic [ADDR_W-1:0] exAddr;
  logic              exInRange;
  logic              portAActive;
  logic              exMemAccess;
  logic [DATA_W-1:0] ramRdataA;
  logic [DATA_W-1:0] ramRdataB;

  assign exAddr      = exMem_q.aluResult[ADDR_W-1:0];
  assign exInRange   = addr_in_range(exAddr, DEPTH);
  assign portAActive = exMem_q.valid && !bus.stall;
  assign exMemAccess = portAActive && (exMem_q.rdEn || exMem_q.wrEn);

  // EX/MEM next state: flush wins over stall so a flushed slot never survives.
  always_comb begin
    exMem_d = exMem_q;
    if (bus.flush) begin
      exMem_d = '0;
    end else if (!bus.stall) begin
      exMem_d.valid     = bus.valid_in;
      exMem_d.wbEn      = bus.writeback_enable;
      exMem_d.rdEn      = bus.mem_read_enable;
      exMem_d.wrEn      = bus.mem_write_enable;
      exMem_d.dest      = bus.instruction_dest;
      exMem_d.aluResult = bus.alu_result;
      exMem_d.writeData = bus.write_data;
    end
  end

  // MEM/WB next state, with enables qualified by valid at capture time.
  always_comb begin
    memWb_d = memWb_q;
    if (!bus.stall) begin
      memWb_d.valid     = exMem_q.valid;
      memWb_d.wbEn      = exMem_q.valid && exMem_q.wbEn;
      memWb_d.load      = exMem_q.valid && exMem_q.rdEn;
      memWb_d.loadOk    = exInRange;
      memWb_d.dest      = exMem_q.dest;
      memWb_d.aluResult = exMem_q.aluResult;
    end
  end

  // The error flag is sticky; port B range misses are gated to zero but
  // never counted as errors.
  always_comb begin
    addrError_d = addrError_q || (exMemAccess && !exInRange);
    portBOk_d   = addr_in_range(bus.address_b, DEPTH);
  end

  // Stage registers and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exMem_q     <= '0;
      memWb_q     <= '0;
      addrError_q <= 1'b0;
      portBOk_q   <= 1'b0;
    end else begin
      exMem_q     <= exMem_d;
      memWb_q     <= memWb_d;
      addrError_q <= addrError_d;
      portBOk_q   <= portBOk_d;
    end
  end

  dp_data_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) uRam (
    .clk      (clk),
    .enA_i    (exMemAccess && exInRange),
    .weA_i    (exMem_q.wrEn),
    .addrA_i  (exAddr[IDX_W-1:0]),
    .wdataA_i (exMem_q.writeData),
    .rdataA_o (ramRdataA),
    .addrB_i  (bus.address_b[IDX_W-1:0]),
    .rdataB_o (ramRdataB)
  );

  // RAM read registers are unreset, so the reset-cleared qualifiers force
  // both data outputs to zero while in reset.
  assign bus.valid_out            = memWb_q.valid;
  assign bus.writeback_enable_out = memWb_q.wbEn;
  assign bus.instruction_dest_out = memWb_q.dest;
  assign bus.alu_result_out       = memWb_q.aluResult;
  assign bus.wb_data              = memWb_q.load ? (memWb_q.loadOk ? ramRdataA : '0)
                                                 : memWb_q.aluResult;
  assign bus.read_data_b          = portBOk_q ? ramRdataB : '0;
  assign bus.addr_error           = addrError_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_pipe
// Directed vector table plus hand-written stall/flush/range/reset sequences,
// followed by randomized traffic compared against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_mem_stage_pipe;
  import mem_stage_pkg::*;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_pipe_if bus();

  mem_stage_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        v;
    logic        wb;
    logic        rd;
    logic        wr;
    logic [3:0]  dest;
    logic [23:0] alu;
    logic [23:0] wd;
  } instr_t;

  typedef struct {
    logic        v, wb, rd, wr;
    logic [3:0]  dest;
    logic [23:0] alu, wd;
    logic [16:0] ab;
    logic        eV, eWe;
    logic [3:0]  eDest;
    logic [23:0] eData;
    logic        chkB;
    logic [23:0] eB;
  } vec_t;

  // Model: RAM as a sparse array, one in-flight slot, and expected WB view.
  logic [23:0] memModel [int];
  instr_t      exSlot;
  logic        expV, expWe, expErr;
  logic [3:0]  expDest;
  logic [23:0] expAlu, expData, expB;
  bit          dataKnown, bKnown;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic wb, input logic rd, input logic wr,
                               input logic [3:0] dest, input logic [23:0] alu,
                               input logic [23:0] wd, input logic [16:0] ab,
                               input logic stall, input logic flush);
    bus.valid_in         = v;
    bus.writeback_enable = wb;
    bus.mem_read_enable  = rd;
    bus.mem_write_enable = wr;
    bus.instruction_dest = dest;
    bus.alu_result       = alu;
    bus.write_data       = wd;
    bus.address_b        = ab;
    bus.stall            = stall;
    bus.flush            = flush;
  endtask

  task automatic bubble(input logic [16:0] ab, input logic stall, input logic flush);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0, ab, stall, flush);
  endtask

  // One edge of the pipeline described as whole instructions: the one in the
  // memory slot completes (touching the RAM), the one on the inputs enters.
  task automatic modelStep();
    int a;
    instr_t inp;
    if (rst) begin
      exSlot = '0;
      expV = 0; expWe = 0; expDest = 0; expAlu = 0; expData = 0; dataKnown = 1;
      expB = 0; bKnown = 1; expErr = 0;
      return;
    end
    a = int'(bus.address_b);
    if (a >= DEPTH) begin
      expB = 0; bKnown = 1;
    end else if (memModel.exists(a)) begin
      expB = memModel[a]; bKnown = 1;
    end else begin
      bKnown = 0;
    end
    if (!bus.stall) begin
      a       = int'(exSlot.alu[16:0]);
      expV    = exSlot.v;
      expWe   = exSlot.v && exSlot.wb;
      expDest = exSlot.dest;
      expAlu  = exSlot.alu;
      if (exSlot.v && exSlot.rd) begin
        if (a >= DEPTH) begin
          expData = 0; dataKnown = 1;
        end else if (memModel.exists(a)) begin
          expData = memModel[a]; dataKnown = 1;
        end else begin
          dataKnown = 0;
        end
      end else begin
        expData = exSlot.alu; dataKnown = 1;
      end
      if (exSlot.v && (exSlot.rd || exSlot.wr) && a >= DEPTH) expErr = 1;
      if (exSlot.v && exSlot.wr && a < DEPTH) memModel[a] = exSlot.wd;
    end
    inp = {bus.valid_in, bus.writeback_enable, bus.mem_read_enable, bus.mem_write_enable,
           bus.instruction_dest, bus.alu_result, bus.write_data};
    if (bus.flush) exSlot = '0;
    else if (!bus.stall) exSlot = inp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    modelStep();
  endtask

  task automatic compareModel(input int n);
    checkOutput($sformatf("rnd%0d_valid", n), 32'(bus.valid_out), 32'(expV));
    checkOutput($sformatf("rnd%0d_wbEn", n), 32'(bus.writeback_enable_out), 32'(expWe));
    checkOutput($sformatf("rnd%0d_dest", n), 32'(bus.instruction_dest_out), 32'(expDest));
    checkOutput($sformatf("rnd%0d_alu", n), 32'(bus.alu_result_out), 32'(expAlu));
    if (dataKnown) checkOutput($sformatf("rnd%0d_wbData", n), 32'(bus.wb_data), 32'(expData));
    if (bKnown) checkOutput($sformatf("rnd%0d_portB", n), 32'(bus.read_data_b), 32'(expB));
    checkOutput($sformatf("rnd%0d_err", n), 32'(bus.addr_error), 32'(expErr));
  endtask

  function automatic logic [16:0] pickAddr();
    case ($urandom_range(0, 39))
      0:       return 17'd1024;
      1:       return 17'd131071;
      2:       return 17'd1023;
      3:       return 17'd2000;
      default: return 17'($urandom_range(0, 31));
    endcase
  endfunction

  vec_t tbl [8];

  initial begin
    // Directed vectors: inputs at edge i, WB and port B expected after it.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 24'h00ABCD, 24'h0, 17'd0,
               1'b0, 1'b0, 4'd0, 24'h000000, 1'b0, 24'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 24'h00000A, 24'h123456, 17'd0,
               1'b1, 1'b1, 4'd3, 24'h00ABCD, 1'b0, 24'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 24'h00000A, 24'h0, 17'd0,
               1'b1, 1'b0, 4'd0, 24'h00000A, 1'b0, 24'h0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 24'h000007, 24'h000777, 17'd0,
               1'b1, 1'b1, 4'd5, 24'h123456, 1'b0, 24'h0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 24'h0, 17'd10,
               1'b1, 1'b0, 4'd0, 24'h000007, 1'b1, 24'h123456};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 24'h000007, 24'hFFFFFF, 17'd7,
               1'b0, 1'b0, 4'd0, 24'h000000, 1'b1, 24'h000777};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 24'h0, 17'd7,
               1'b1, 1'b0, 4'd0, 24'h000007, 1'b1, 24'h000777};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 24'h0, 17'd7,
               1'b0, 1'b0, 4'd0, 24'h000000, 1'b1, 24'hFFFFFF};

    // Reset, then a store that must survive and one that must be discarded.
    bubble(17'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 24'd12, 24'h000C0C, 17'd0, 1'b0, 1'b0);
    tick();
    bubble(17'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 24'h000606, 24'd0, 17'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 24'd12, 24'hBADBAD, 17'd0, 1'b0, 1'b0);
    tick();
    checkOutput("pre_rst_valid", 32'(bus.valid_out), 32'd1);
    checkOutput("pre_rst_dest", 32'(bus.instruction_dest_out), 32'd6);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_valid", 32'(bus.valid_out), 32'd0);
    checkOutput("rst_wbEn", 32'(bus.writeback_enable_out), 32'd0);
    checkOutput("rst_dest", 32'(bus.instruction_dest_out), 32'd0);
    checkOutput("rst_wbData", 32'(bus.wb_data), 32'd0);
    checkOutput("rst_alu", 32'(bus.alu_result_out), 32'd0);
    checkOutput("rst_portB", 32'(bus.read_data_b), 32'd0);
    checkOutput("rst_err", 32'(bus.addr_error), 32'd0);
    bubble(17'd12, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("rst_discard_store", 32'(bus.read_data_b), 32'h000C0C);

    // Table-driven ALU/store/load/read-first vectors.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].v, tbl[i].wb, tbl[i].rd, tbl[i].wr, tbl[i].dest,
                    tbl[i].alu, tbl[i].wd, tbl[i].ab, 1'b0, 1'b0);
      tick();
      checkOutput($sformatf("vec%0d_valid", i), 32'(bus.valid_out), 32'(tbl[i].eV));
      checkOutput($sformatf("vec%0d_wbEn", i), 32'(bus.writeback_enable_out), 32'(tbl[i].eWe));
      checkOutput($sformatf("vec%0d_dest", i), 32'(bus.instruction_dest_out), 32'(tbl[i].eDest));
      checkOutput($sformatf("vec%0d_wbData", i), 32'(bus.wb_data), 32'(tbl[i].eData));
      if (tbl[i].chkB) checkOutput($sformatf("vec%0d_portB", i), 32'(bus.read_data_b), 32'(tbl[i].eB));
    end

    // Stall: store held 3 cycles behind a frozen ALU result.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 24'd5, 24'h0000AA, 17'd5, 1'b0, 1'b0);
    tick();
    bubble(17'd5, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 24'h000111, 24'd0, 17'd5, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 24'd5, 24'h000001, 17'd5, 1'b0, 1'b0);
    tick();
    checkOutput("stall_s0_dest", 32'(bus.instruction_dest_out), 32'd9);
    for (int k = 1; k <= 3; k++) begin
      bubble(17'd5, 1'b1, 1'b0);
      tick();
      checkOutput($sformatf("stall_s%0d_valid", k), 32'(bus.valid_out), 32'd1);
      checkOutput($sformatf("stall_s%0d_dest", k), 32'(bus.instruction_dest_out), 32'd9);
      checkOutput($sformatf("stall_s%0d_wbData", k), 32'(bus.wb_data), 32'h000111);
      checkOutput($sformatf("stall_s%0d_portB", k), 32'(bus.read_data_b), 32'h0000AA);
    end
    bubble(17'd5, 1'b0, 1'b0);
    tick();
    checkOutput("stall_s4_valid", 32'(bus.valid_out), 32'd1);
    checkOutput("stall_s4_wbEn", 32'(bus.writeback_enable_out), 32'd0);
    checkOutput("stall_s4_wbData", 32'(bus.wb_data), 32'h000005);
    checkOutput("stall_s4_portB", 32'(bus.read_data_b), 32'h0000AA);
    tick();
    checkOutput("stall_s5_valid", 32'(bus.valid_out), 32'd0);
    checkOutput("stall_s5_portB", 32'(bus.read_data_b), 32'h000001);

    // Flush: flushed load, flushed stores (in and out of range), stall+flush.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd4, 24'd10, 24'd0, 17'd10, 1'b0, 1'b1);
    tick();
    bubble(17'd10, 1'b0, 1'b0);
    tick();
    checkOutput("flush_ld_valid", 32'(bus.valid_out), 32'd0);
    checkOutput("flush_ld_wbEn", 32'(bus.writeback_enable_out), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 24'd10, 24'h0F0F0F, 17'd10, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 24'd3000, 24'h0F0F0F, 17'd10, 1'b0, 1'b1);
    tick();
    bubble(17'd10, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("flush_st_portB", 32'(bus.read_data_b), 32'h123456);
    checkOutput("flush_st_err", 32'(bus.addr_error), 32'd0);
    checkOutput("flush_st_valid", 32'(bus.valid_out), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 24'h000222, 24'd0, 17'd10, 1'b0, 1'b0);
    tick();
    bubble(17'd10, 1'b1, 1'b1);
    tick();
    bubble(17'd10, 1'b0, 1'b0);
    tick();
    checkOutput("stallflush_valid", 32'(bus.valid_out), 32'd0);
    checkOutput("stallflush_dest", 32'(bus.instruction_dest_out), 32'd0);

    // Range: aliasing word 976 must stay untouched by a store to 2000.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 24'd976, 24'h0003D0, 17'd2000, 1'b0, 1'b0);
    tick();
    bubble(17'd2000, 1'b0, 1'b0);
    tick();
    checkOutput("range_portB_oob", 32'(bus.read_data_b), 32'd0);
    checkOutput("range_portB_noerr", 32'(bus.addr_error), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 24'd2000, 24'hDEAD00, 17'd976, 1'b0, 1'b0);
    tick();
    checkOutput("range_err_early", 32'(bus.addr_error), 32'd0);
    bubble(17'd976, 1'b0, 1'b0);
    tick();
    checkOutput("range_err_set", 32'(bus.addr_error), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd8, 24'd2000, 24'd0, 17'd976, 1'b0, 1'b0);
    tick();
    checkOutput("range_no_write", 32'(bus.read_data_b), 32'h0003D0);
    bubble(17'd976, 1'b0, 1'b0);
    tick();
    checkOutput("range_ld_valid", 32'(bus.valid_out), 32'd1);
    checkOutput("range_ld_dest", 32'(bus.instruction_dest_out), 32'd8);
    checkOutput("range_ld_wbData", 32'(bus.wb_data), 32'd0);
    checkOutput("range_ld_alu", 32'(bus.alu_result_out), 32'd2000);
    tick();
    checkOutput("range_err_sticky", 32'(bus.addr_error), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("range_err_cleared", 32'(bus.addr_error), 32'd0);
    tick();
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [16:0] addr;
      logic [23:0] hi;
      addr = pickAddr();
      hi   = 24'($urandom);
      case ($urandom_range(0, 3))
        0: applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0, pickAddr(), 1'b0, 1'b0);
        1: applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0, 4'($urandom), 24'($urandom),
                         24'd0, pickAddr(), 1'b0, 1'b0);
        2: applyStimulus(1'b1, 1'($urandom), 1'b1, 1'b0, 4'($urandom), {hi[23:17], addr},
                         24'd0, pickAddr(), 1'b0, 1'b0);
        default: applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'($urandom), {hi[23:17], addr},
                               24'($urandom), pickAddr(), 1'b0, 1'b0);
      endcase
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      tick();
      compareModel(n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
